mem_stage: RTL
==============

Name: mem_stage

Overview:
Memory-access pipeline stage placed directly after the execute stage. It consumes the execute-to-memory register bundle, performs loads and stores on a single-outstanding req/ack data bus, and stalls the front of the pipeline while an access is pending. It also handles byte-lane steering and sign/zero extension, and drives the memory-to-writeback pipeline register plus the memory-stage forwarding value.

Parameters:
TIMEOUT, 255, maximum cycles spent in WAIT before an access is abandoned; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_alu_res  in  32  effective address, or ALU result for non-memory instructions
i_rs2  in  32  store data
i_mem_w_en  in  1  store
i_func3  in  3  access size and signedness
i_pc4  in  32  PC+4
i_w_idx  in  5  destination register
i_wb_sel  in  2  00 ALU, 01 MEM, 10 PC4
i_wb_en  in  1  register write enable
i_bus_ack  in  1  bus completion
i_bus_rdata  in  32  bus read word
o_bus_req  out  1  bus request (registered)
o_bus_we  out  1  bus write
o_bus_addr  out  32  word address, {addr[31:2],2'b00}
o_bus_wdata  out  32  lane-replicated store data
o_bus_be  out  4  byte enables
o_stall  out  1  combinational; hold upstream stages
o_mem_fw_data  out  32  combinational; equals i_alu_res
o_alu_res, o_rd_data, o_pc4  out  32 each  memory-to-writeback register fields
o_w_idx  out  5  memory-to-writeback register field
o_wb_sel  out  2  memory-to-writeback register field
o_wb_en  out  1  memory-to-writeback register field
o_misalign  out  1  one-cycle pulse: misaligned access or illegal func3
o_bus_err  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset: every registered output is 0 and state is IDLE. Reset during WAIT drops o_bus_req at that edge. An ack arriving after reset is ignored.
- Access types:
  - load = i_wb_en && i_wb_sel==01 && !i_mem_w_en.
  - store = i_mem_w_en.
  - A non-access instruction passes through in one cycle: o_alu_res, o_pc4, o_w_idx, o_wb_sel and o_wb_en are registered; o_rd_data holds.
- Legal func3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned or illegal access: no bus activity, no stall, o_misalign=1 for one cycle, retired with o_wb_en=0.
- Byte enables (off = addr[1:0]):
  - Byte: 0001<<off.
  - Halfword: 0011<<off.
  - Word: 1111.
- Store data: byte replicated to all 4 lanes; halfword replicated to both halves. Loads drive be=1111 and we=0.
- FSM:
  - IDLE: on a legal access, bus outputs are registered at the edge and state moves to WAIT. o_stall=1 in that cycle.
  - WAIT: o_bus_req=1; address, data, we and be are held stable. o_stall = !i_bus_ack.
  - On i_bus_ack in WAIT: the lane is selected from rdata by off, extended per func3 and registered into o_rd_data. The instruction retires into the writeback register, o_bus_req drops, and state returns to IDLE.
  - Stores retire with the incoming o_wb_en (normally 0).
- Latency: the minimum memory access is 2 cycles (issue cycle plus ack in the first WAIT cycle). There are no back-to-back requests without one IDLE cycle between them.
- Stall bubble: on every stalled edge, o_wb_en<=0 and the other writeback fields hold.
- Ack handling: an ack in IDLE is ignored. i_bus_rdata is sampled only on the ack cycle.
- Timeout: a counter clears on entering WAIT and increments each WAIT cycle without ack. When count==TIMEOUT-1 with no ack:
  - o_bus_req drops and state returns to IDLE;
  - o_bus_err=1 for one cycle and o_stall=0 in that cycle;
  - the instruction is retired with o_wb_en=0.
  - An ack in that same cycle wins and no error is raised.

Test Plan:
- Forwarding pass-through: ADD result 0x1234, wb_sel=00, wb_en=1 → next cycle o_alu_res=0x1234, o_wb_en=1, o_stall never high, o_mem_fw_data=0x1234 combinationally.
- Byte/halfword loads: LB addr 0x103, ack with rdata 0x80FF_0000 after 3 WAIT cycles → o_rd_data=0xFFFFFF80, o_stall high for 4 cycles, o_wb_en pulses once. LHU addr 0x102 with the same data → 0x000080FF.
- SB addr 0x201, rs2=0xAABBCCDD → o_bus_addr=0x200, be=0010, wdata=0xDDDDDDDD, we=1; o_wb_en=0 after ack.
- LW addr 0x6 → o_misalign pulse, o_bus_req stays 0, no stall, o_wb_en=0. func3=011 load behaves the same.
- TIMEOUT=4 with no ack → o_bus_req high 4 cycles then 0, o_bus_err pulse, stall released.
- rst asserted mid-WAIT then late ack → all outputs 0, ack ignored, the next LW completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a single-outstanding
// req/ack bus, stalls upstream while pending, and feeds the writeback register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_alu_res,
    input  logic [31:0] i_rs2,
    input  logic        i_mem_w_en,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_pc4,
    input  logic [4:0]  i_w_idx,
    input  logic [1:0]  i_wb_sel,
    input  logic        i_wb_en,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    output logic        o_stall,
    output logic [31:0] o_mem_fw_data,
    output logic [31:0] o_alu_res,
    output logic [31:0] o_rd_data,
    output logic [31:0] o_pc4,
    output logic [4:0]  o_w_idx,
    output logic [1:0]  o_wb_sel,
    output logic        o_wb_en,
    output logic        o_misalign,
    output logic        o_bus_err
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    func3_q, func3_d;
    logic [1:0]    off_q, off_d;
    logic          req_q, req_d, we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   alu_res_q, alu_res_d, rd_data_q, rd_data_d, pc4_q, pc4_d;
    logic [4:0]    w_idx_q, w_idx_d;
    logic [1:0]    wb_sel_q, wb_sel_d;
    logic          wb_en_q, wb_en_d, misalign_q, misalign_d, bus_err_q, bus_err_d;

    logic        is_store, is_load, is_acc, f3_legal, mis, bad, go;
    logic        ack, timeout_hit;
    logic [31:0] lane_w, rd_ext;

    assign is_store = i_mem_w_en;
    assign is_load  = i_wb_en && (i_wb_sel == 2'b01) && !i_mem_w_en;
    assign is_acc   = is_store || is_load;

    always_comb begin
        case (i_func3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !is_store;
            default:                f3_legal = 1'b0;
        endcase
    end

    assign mis = ((i_func3[1:0] == 2'b01) && i_alu_res[0]) ||
                 ((i_func3[1:0] == 2'b10) && (i_alu_res[1:0] != 2'b00));
    assign bad = is_acc && (!f3_legal || mis);
    assign go  = is_acc && !bad;

    assign ack         = (state_q == WAIT) && i_bus_ack;
    // An ack in the final allowed cycle beats the timeout.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == WAIT) && !i_bus_ack && (cnt_q == CNT_LAST);

    assign o_stall       = (state_q == IDLE) ? go : !(i_bus_ack || timeout_hit);
    assign o_mem_fw_data = i_alu_res;

    assign lane_w = i_bus_rdata >> {off_q, 3'b000};
    always_comb begin
        case (func3_q[1:0])
            2'b00:   rd_ext = {{24{lane_w[7]  && !func3_q[2]}}, lane_w[7:0]};
            2'b01:   rd_ext = {{16{lane_w[15] && !func3_q[2]}}, lane_w[15:0]};
            default: rd_ext = i_bus_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        func3_d    = func3_q;
        off_d      = off_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        alu_res_d  = alu_res_q;
        rd_data_d  = rd_data_q;
        pc4_d      = pc4_q;
        w_idx_d    = w_idx_q;
        wb_sel_d   = wb_sel_q;
        wb_en_d    = 1'b0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        if (state_q == IDLE) begin
            if (go) begin
                state_d = WAIT;
                cnt_d   = '0;
                func3_d = i_func3;
                off_d   = i_alu_res[1:0];
                req_d   = 1'b1;
                we_d    = is_store;
                addr_d  = {i_alu_res[31:2], 2'b00};
                case (i_func3[1:0])
                    2'b00:   wdata_d = {4{i_rs2[7:0]}};
                    2'b01:   wdata_d = {2{i_rs2[15:0]}};
                    default: wdata_d = i_rs2;
                endcase
                if (!is_store)                 be_d = 4'b1111;
                else if (i_func3[1:0] == 2'b00) be_d = 4'b0001 << i_alu_res[1:0];
                else if (i_func3[1:0] == 2'b01) be_d = 4'b0011 << i_alu_res[1:0];
                else                            be_d = 4'b1111;
            end else begin
                alu_res_d  = i_alu_res;
                pc4_d      = i_pc4;
                w_idx_d    = i_w_idx;
                wb_sel_d   = i_wb_sel;
                wb_en_d    = i_wb_en && !bad;
                misalign_d = bad;
            end
        end else if (ack || timeout_hit) begin
            state_d   = IDLE;
            req_d     = 1'b0;
            alu_res_d = i_alu_res;
            pc4_d     = i_pc4;
            w_idx_d   = i_w_idx;
            wb_sel_d  = i_wb_sel;
            wb_en_d   = ack && i_wb_en;
            bus_err_d = timeout_hit;
            if (ack && !we_q) rd_data_d = rd_ext;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            func3_q    <= '0;
            off_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            alu_res_q  <= '0;
            rd_data_q  <= '0;
            pc4_q      <= '0;
            w_idx_q    <= '0;
            wb_sel_q   <= '0;
            wb_en_q    <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            func3_q    <= func3_d;
            off_q      <= off_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            alu_res_q  <= alu_res_d;
            rd_data_q  <= rd_data_d;
            pc4_q      <= pc4_d;
            w_idx_q    <= w_idx_d;
            wb_sel_q   <= wb_sel_d;
            wb_en_q    <= wb_en_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign o_bus_req   = req_q;
    assign o_bus_we    = we_q;
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;
    assign o_bus_be    = be_q;
    assign o_alu_res   = alu_res_q;
    assign o_rd_data   = rd_data_q;
    assign o_pc4       = pc4_q;
    assign o_w_idx     = w_idx_q;
    assign o_wb_sel    = wb_sel_q;
    assign o_wb_en     = wb_en_q;
    assign o_misalign  = misalign_q;
    assign o_bus_err   = bus_err_q;
endmodule
